telem_pkt: RTL

TELEM_PKT -- requirements
Module: telem_pkt

---
 rtl/telem_pkt.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/telem_pkt.sv
// telem_pkt: decimating telemetry framer with a UART 8N1 transmitter.
// Every DECIM-th vld pulse (while enable=1) snapshots the sensor inputs into
// an 11-byte frame (A5h header, pitch, motor speeds, battery, flags, XOR
// checksum). The frame is then shifted out LSB first on TX.
//   clk, rst        clock and asynchronous active-high reset
//   vld             one-cycle pulse marking a new pitch sample
//   ptch            signed pitch
//   lft_*/rght_*    motor speed magnitudes and reverse flags
//   batt            battery A2D reading
//   pwr_up, en_steer, too_fast, batt_low  status flags
//   enable          telemetry enable level
//   TX              UART serial out, idle high
//   busy            a frame is in flight
//   frm_drop        one-cycle pulse when a triggered frame is discarded
module telem_pkt #(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned DECIM    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vld,
  input  logic [15:0] ptch,
  input  logic [10:0] lft_spd,
  input  logic        lft_rev,
  input  logic [10:0] rght_spd,
  input  logic        rght_rev,
  input  logic [11:0] batt,
  input  logic        pwr_up,
  input  logic        en_steer,
  input  logic        too_fast,
  input  logic        batt_low,
  input  logic        enable,
  output logic        TX,
  output logic        busy,
  output logic        frm_drop
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [7:0]  DEC_LAST  = 8'(DECIM - 1);
  localparam logic [3:0]  LAST_BYTE = 4'd10;

  state_t      state_q;
  logic [7:0]  dec_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [3:0]  byte_q;
  logic [87:0] frame_q;
  logic        tx_q;
  logic        busy_q;
  logic        drop_q;

  logic        trigger;
  logic        baud_done;
  logic        frame_end;
  logic        accept;
  logic [79:0] snap;
  logic [7:0]  chk;

  always_comb begin
    trigger   = enable && vld && (dec_q == DEC_LAST);
    baud_done = (baud_q == BAUD_LAST);
    frame_end = (state_q == STOP) && baud_done && (byte_q == LAST_BYTE);
    // A trigger landing on the final stop-bit cycle is taken directly, so the
    // next start bit follows the stop bit with no idle cycle.
    accept    = trigger && ((state_q == IDLE) || frame_end);

    // Byte 0 sits in the low bits so the frame shifts out from bit 0 upward.
    snap = {{4'b0, pwr_up, en_steer, too_fast, batt_low},
            batt[7:0],
            {4'b0, batt[11:8]},
            rght_spd[7:0],
            {rght_rev, 4'b0, rght_spd[10:8]},
            lft_spd[7:0],
            {lft_rev, 4'b0, lft_spd[10:8]},
            ptch[7:0],
            ptch[15:8],
            8'hA5};
    chk = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      chk = chk ^ snap[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dec_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= trigger && !accept;

      if (!enable) begin
        dec_q <= '0;
      end else if (vld) begin
        dec_q <= (dec_q == DEC_LAST) ? '0 : dec_q + 8'd1;
      end

      if (accept) begin
        state_q <= START;
        frame_q <= {chk, snap};
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
        baud_q  <= '0;
        bit_q   <= '0;
        byte_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
          end
          START: begin
            if (baud_done) begin
              baud_q  <= '0;
              bit_q   <= '0;
              state_q <= DATA;
              tx_q    <= frame_q[0];
            end else begin
              baud_q <= baud_q + 16'd1;
            end
          end
          DATA: begin
            if (baud_done) begin
              baud_q  <= '0;
              // Shifting per data bit leaves the next byte's bit 0 in place
              // once all eight bits have gone out.
              frame_q <= frame_q >> 1;
              bit_q   <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end else begin
                tx_q <= frame_q[1];
              end
            end else begin
              baud_q <= baud_q + 16'd1;
            end
          end
          STOP: begin
            if (baud_done) begin
              baud_q <= '0;
              if (byte_q == LAST_BYTE) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                tx_q    <= 1'b1;
              end else begin
                byte_q  <= byte_q + 4'd1;
                state_q <= START;
                tx_q    <= 1'b0;
              end
            end else begin
              baud_q <= baud_q + 16'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign frm_drop = drop_q;

endmodule
